// File: rtl/sum_stage_acc_pkg.sv
// Shared types and defaults for the PE sum stage (SS) and its lanes.
// Control word carried with each multiplier-stage beat, and the tag
// forwarded to post-processing with each completed PSUM vector.
package sum_stage_acc_pkg;

    // Default geometry of one PE column
    localparam int unsigned PEROW_DEF   = 4;
    localparam int unsigned DWD_DEF     = 16;
    localparam int unsigned PSUMDWD_DEF = 24;

    // Per-beat shift amount width; max shift is 2**SHTW-1
    localparam int unsigned SHTW = 3;

    // Post-process control tag width
    localparam int unsigned TAGW = 4;

    typedef logic [TAGW-1:0] ppctl_t;

    typedef struct packed {
        logic            first;
        logic            last;
        logic [SHTW-1:0] sht;
        ppctl_t          tag;
    } ssctl_t;

endpackage

// File: rtl/sum_acc_lane.sv
// One row of the sum stage: shift-accumulate of signed beats into a
// PSUMDWD-bit accumulator, publishing the result on the group's last beat.
// Build option: SUMSTAGE_SAT_EN selects saturating shift/add with a sticky
// per-group overflow flag; otherwise arithmetic wraps and ovf is tied 0.
module sum_acc_lane
    import sum_stage_acc_pkg::*;
#(
    parameter int unsigned DWD     = DWD_DEF,
    parameter int unsigned PSUMDWD = PSUMDWD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fire,
    input  logic               first,
    input  logic               last,
    input  logic [SHTW-1:0]    sht,
    input  logic [DWD-1:0]     data,
    output logic [PSUMDWD-1:0] sum,
    output logic               ovf
);

    logic signed [DWD-1:0]     data_s;
    logic signed [PSUMDWD-1:0] acc_q;
    logic signed [PSUMDWD-1:0] base;
    logic signed [PSUMDWD-1:0] nxt;

    assign data_s = data;
    // A first beat starts the group from zero regardless of leftover acc
    assign base   = first ? '0 : acc_q;

`ifdef SUMSTAGE_SAT_EN
    localparam int unsigned MAXSH = (2 ** SHTW) - 1;
    localparam int unsigned WIDE  = PSUMDWD + MAXSH;
    localparam logic signed [PSUMDWD-1:0] SMAX = {1'b0, {(PSUMDWD-1){1'b1}}};
    localparam logic signed [PSUMDWD-1:0] SMIN = {1'b1, {(PSUMDWD-1){1'b0}}};

    logic signed [WIDE-1:0]    wide;
    logic signed [PSUMDWD-1:0] shifted;
    logic signed [PSUMDWD:0]   sum_w;
    logic                      sh_ovf;
    logic                      add_ovf;
    logic                      beat_ovf;
    logic                      ovf_q;
    logic                      ovf_out_q;
    logic                      ovf_base;

    // Saturating shift then saturating add, flagging either clip
    always_comb begin
        wide     = WIDE'(base) <<< sht;
        // Shift overflowed if the wide result is not a sign-extension of its low bits
        sh_ovf   = (wide != WIDE'($signed(wide[PSUMDWD-1:0])));
        shifted  = sh_ovf ? (base[PSUMDWD-1] ? SMIN : SMAX) : wide[PSUMDWD-1:0];
        sum_w    = (PSUMDWD+1)'(shifted) + (PSUMDWD+1)'(data_s);
        add_ovf  = (sum_w[PSUMDWD] != sum_w[PSUMDWD-1]);
        nxt      = add_ovf ? (sum_w[PSUMDWD] ? SMIN : SMAX) : sum_w[PSUMDWD-1:0];
        beat_ovf = sh_ovf | add_ovf;
        ovf_base = first ? 1'b0 : ovf_q;
    end

    // Sticky overflow within a group; reported and cleared on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            ovf_out_q <= 1'b0;
        end else if (fire) begin
            if (last) begin
                ovf_out_q <= ovf_base | beat_ovf;
                ovf_q     <= 1'b0;
            end else begin
                ovf_q     <= ovf_base | beat_ovf;
            end
        end
    end

    assign ovf = ovf_out_q;
`else
    // Two's-complement wrap; bits shifted past PSUMDWD are dropped
    always_comb begin
        nxt = (base <<< sht) + PSUMDWD'(data_s);
    end

    assign ovf = 1'b0;
`endif

    logic [PSUMDWD-1:0] sum_q;

    // Accumulate on non-last beats; publish and clear acc on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sum_q <= '0;
        end else if (fire) begin
            if (last) begin
                sum_q <= nxt;
                acc_q <= '0;
            end else begin
                acc_q <= nxt;
            end
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/sum_stage_acc.sv
// PE sum stage: per-row shift-accumulate of multiplier-stage beats, emitting
// one PSUM vector plus its post-process tag per group to the PP stage.
// Build option: SUMSTAGE_SAT_EN enables saturating arithmetic and o_ovf.
module sum_stage_acc
    import sum_stage_acc_pkg::*;
#(
    parameter int unsigned PEROW   = PEROW_DEF,
    parameter int unsigned DWD     = DWD_DEF,
    parameter int unsigned PSUMDWD = PSUMDWD_DEF
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  ssctl_t                          i_ctl,
    input  logic                            MS_rdy,
    output logic                            MS_ack,
    input  logic [PEROW-1:0][DWD-1:0]       i_data,
    output logic                            SS_rdy,
    input  logic                            SS_ack,
    output logic [PEROW-1:0][PSUMDWD-1:0]   o_sum,
    output ppctl_t                          o_ppctl,
    output logic [PEROW-1:0]                o_ovf
);

    logic fire;
    logic fire_last;

    // Only a last beat needs the output register; it may reuse it the same
    // cycle the current result is taken.
    assign MS_ack    = MS_rdy && (!i_ctl.last || !SS_rdy || SS_ack);
    assign fire      = MS_rdy && MS_ack;
    assign fire_last = fire && i_ctl.last;

    // Output valid and tag: set by a last beat, cleared by downstream accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            SS_rdy  <= 1'b0;
            o_ppctl <= '0;
        end else if (fire_last) begin
            SS_rdy  <= 1'b1;
            o_ppctl <= i_ctl.tag;
        end else if (SS_ack) begin
            SS_rdy  <= 1'b0;
        end
    end

    for (genvar r = 0; r < PEROW; r++) begin : g_lane
        sum_acc_lane #(
            .DWD     (DWD),
            .PSUMDWD (PSUMDWD)
        ) u_lane (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .fire  (fire),
            .first (i_ctl.first),
            .last  (i_ctl.last),
            .sht   (i_ctl.sht),
            .data  (i_data[r]),
            .sum   (o_sum[r]),
            .ovf   (o_ovf[r])
        );
    end

endmodule

// File: tb/tb_sum_stage_acc.sv
// Directed-vector bench for sum_stage_acc with hand-computed expectations.
module tb_sum_stage_acc;
    import sum_stage_acc_pkg::*;

    localparam int PEROW   = 4;
    localparam int DWD     = 16;
    localparam int PSUMDWD = 24;

    typedef logic [PEROW-1:0][DWD-1:0] vec_t;

    logic                          i_clk = 1'b0;
    logic                          i_rst_n;
    ssctl_t                        i_ctl;
    logic                          MS_rdy;
    logic                          MS_ack;
    vec_t                          i_data;
    logic                          SS_rdy;
    logic                          SS_ack;
    logic [PEROW-1:0][PSUMDWD-1:0] o_sum;
    ppctl_t                        o_ppctl;
    logic [PEROW-1:0]              o_ovf;

    int checks   = 0;
    int failures = 0;

    sum_stage_acc #(
        .PEROW   (PEROW),
        .DWD     (DWD),
        .PSUMDWD (PSUMDWD)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ctl   (i_ctl),
        .MS_rdy  (MS_rdy),
        .MS_ack  (MS_ack),
        .i_data  (i_data),
        .SS_rdy  (SS_rdy),
        .SS_ack  (SS_ack),
        .o_sum   (o_sum),
        .o_ppctl (o_ppctl),
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic vec_t rep(input logic [DWD-1:0] d);
        vec_t v;
        for (int r = 0; r < PEROW; r++) v[r] = d;
        return v;
    endfunction

    // Present a beat and hold it until accepted (bounded); returns at posedge+1
    task automatic send_vec(input logic first, input logic last, input logic [SHTW-1:0] sht,
                            input logic [TAGW-1:0] tag, input vec_t d);
        bit done = 1'b0;
        i_ctl  = '{first: first, last: last, sht: sht, tag: tag};
        i_data = d;
        MS_rdy = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (MS_ack) done = 1'b1;
            @(posedge i_clk);
            #1;
        end
        MS_rdy = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic first, input logic last, input logic [SHTW-1:0] sht,
                        input logic [TAGW-1:0] tag, input logic [DWD-1:0] d);
        send_vec(first, last, sht, tag, rep(d));
    endtask

    task automatic pulse_ack();
        SS_ack = 1'b1;
        @(posedge i_clk);
        #1;
        SS_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        MS_rdy  = 1'b0;
        SS_ack  = 1'b0;
        i_ctl   = '0;
        i_data  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ss_rdy", 32'(SS_rdy), 32'd0);
        check("rst_sum0", 32'(o_sum[0]), 32'd0);
        check("rst_ppctl", 32'(o_ppctl), 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        check("rst_ms_ack", 32'(MS_ack), 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // 1: pending output plus an open group, then reset mid-group
        send(1'b1, 1'b1, 3'd0, 4'd3, 16'd9);
        check("t1_pre_rdy", 32'(SS_rdy), 32'd1);
        check("t1_pre_sum", 32'(o_sum[1]), 32'd9);
        send(1'b1, 1'b0, 3'd0, 4'd2, 16'd4);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t1_rst_rdy", 32'(SS_rdy), 32'd0);
        check("t1_rst_sum", 32'(o_sum[2]), 32'd0);
        check("t1_rst_ppctl", 32'(o_ppctl), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        // Non-first beat: the discarded partial acc (4) must not leak in
        send(1'b0, 1'b1, 3'd0, 4'd1, 16'd5);
        check("t1_sum0", 32'(o_sum[0]), 32'd5);
        check("t1_sum3", 32'(o_sum[3]), 32'd5);
        check("t1_rdy", 32'(SS_rdy), 32'd1);
        check("t1_ppctl", 32'(o_ppctl), 32'd1);
        pulse_ack();
        check("t1_ack_clr", 32'(SS_rdy), 32'd0);

        // 2: bit-serial 1,0,1 with sht=1, idle gap between beats
        send(1'b1, 1'b0, 3'd1, 4'd4, 16'd1);
        repeat (2) @(posedge i_clk);
        #1;
        send(1'b0, 1'b0, 3'd1, 4'd4, 16'd0);
        check("t2_not_yet", 32'(SS_rdy), 32'd0);
        send(1'b0, 1'b1, 3'd1, 4'd4, 16'd1);
        check("t2_rdy", 32'(SS_rdy), 32'd1);
        for (int r = 0; r < PEROW; r++) check($sformatf("t2_sum%0d", r), 32'(o_sum[r]), 32'd5);
        check("t2_ppctl", 32'(o_ppctl), 32'd4);
        pulse_ack();

        // Group without first after a completed group starts from 0: (0*2+3)*2+1
        send(1'b0, 1'b0, 3'd1, 4'd5, 16'd3);
        send(1'b0, 1'b1, 3'd1, 4'd5, 16'd1);
        check("t2b_sum", 32'(o_sum[2]), 32'd7);
        pulse_ack();

        // 3: signed single-beat groups, different data per row
        send_vec(1'b1, 1'b1, 3'd0, 4'd6, {16'h7FFF, 16'h8000, 16'd7, 16'hFFFD});
        check("t3_neg3", 32'(o_sum[0]), 32'hFFFFFD);
        check("t3_pos7", 32'(o_sum[1]), 32'h000007);
        check("t3_min", 32'(o_sum[2]), 32'hFF8000);
        check("t3_max", 32'(o_sum[3]), 32'h007FFF);

        // 4: backpressure with SS_rdy=1 and SS_ack=0
        i_ctl  = '{first: 1'b1, last: 1'b1, sht: 3'd0, tag: 4'd7};
        i_data = rep(16'd100);
        MS_rdy = 1'b1;
        #1;
        check("t4_stall", 32'(MS_ack), 32'd0);
        @(posedge i_clk);
        #1;
        check("t4_hold_sum", 32'(o_sum[0]), 32'hFFFFFD);
        check("t4_hold_ppctl", 32'(o_ppctl), 32'd6);
        check("t4_hold_rdy", 32'(SS_rdy), 32'd1);
        i_ctl  = '{first: 1'b1, last: 1'b0, sht: 3'd0, tag: 4'd7};
        i_data = rep(16'd20);
        #1;
        check("t4_nonlast_ack", 32'(MS_ack), 32'd1);
        @(posedge i_clk);
        #1;
        i_ctl  = '{first: 1'b0, last: 1'b1, sht: 3'd0, tag: 4'd7};
        i_data = rep(16'd100);
        #1;
        check("t4_stall2", 32'(MS_ack), 32'd0);
        SS_ack = 1'b1;
        #1;
        check("t4_ack_pass", 32'(MS_ack), 32'd1);
        @(posedge i_clk);
        #1;
        SS_ack = 1'b0;
        MS_rdy = 1'b0;
        check("t4_rdy_stays", 32'(SS_rdy), 32'd1);
        check("t4_new_sum", 32'(o_sum[0]), 32'd120);
        check("t4_new_ppctl", 32'(o_ppctl), 32'd7);
        pulse_ack();
        check("t4_cleared", 32'(SS_rdy), 32'd0);

        // 5: back-to-back single-beat groups with SS_ack held high
        SS_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_ctl  = '{first: 1'b1, last: 1'b1, sht: 3'd0, tag: 4'(8 + i)};
            i_data = rep(16'(10 * i + 1));
            MS_rdy = 1'b1;
            #1;
            check($sformatf("t5_ack%0d", i), 32'(MS_ack), 32'd1);
            @(posedge i_clk);
            #1;
            check($sformatf("t5_rdy%0d", i), 32'(SS_rdy), 32'd1);
            check($sformatf("t5_tag%0d", i), 32'(o_ppctl), 32'(8 + i));
            check($sformatf("t5_sum%0d", i), 32'(o_sum[1]), 32'(10 * i + 1));
        end
        MS_rdy = 1'b0;
        @(posedge i_clk);
        #1;
        SS_ack = 1'b0;
        check("t5_drain", 32'(SS_rdy), 32'd0);

        // 6: build acc=0x7FFFF0 then add 0x20 with sht=0
        send(1'b1, 1'b0, 3'd0, 4'd12, 16'h7FFF);
        send(1'b0, 1'b0, 3'd7, 4'd12, 16'h0078);
        send(1'b0, 1'b0, 3'd1, 4'd12, 16'h0000);
        send(1'b0, 1'b1, 3'd0, 4'd12, 16'h0020);
`ifdef SUMSTAGE_SAT_EN
        check("t6_sum0", 32'(o_sum[0]), 32'h7FFFFF);
        check("t6_sum3", 32'(o_sum[3]), 32'h7FFFFF);
        check("t6_ovf", 32'(o_ovf), 32'hF);
`else
        check("t6_sum0", 32'(o_sum[0]), 32'h800010);
        check("t6_sum3", 32'(o_sum[3]), 32'h800010);
        check("t6_ovf", 32'(o_ovf), 32'h0);
`endif
        pulse_ack();
        // Next group starts clean: no overflow carried over
        send(1'b1, 1'b1, 3'd0, 4'd13, 16'd1);
        check("t6_next_sum", 32'(o_sum[0]), 32'd1);
        check("t6_next_ovf", 32'(o_ovf), 32'h0);
        pulse_ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
